// File: rtl/uart_periph.sv
// uart_periph: register-mapped full-duplex UART with TX/RX FIFOs, run-time baud divisor, sticky errors.
// Define UART_PARITY_EN to add an even-parity bit to every frame (TX inserts, RX checks).
module uart_periph #(
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned FifoDepth  = 8,
    parameter int unsigned DefaultDiv = 53
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  logic        rd_en_i,
    input  logic [1:0]  addr_i,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        irq_o
);
    localparam int unsigned PtrW    = $clog2(FifoDepth);
    localparam logic [3:0]  LastIdx = 4'(DataWidth - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    logic tx_wr, rx_rd, stat_wr, div_wr;
    assign tx_wr   = wr_en_i && (addr_i == 2'd0);
    assign rx_rd   = rd_en_i && (addr_i == 2'd1);
    assign stat_wr = wr_en_i && (addr_i == 2'd2);
    assign div_wr  = wr_en_i && (addr_i == 2'd3);

    // Shared 16x baud tick
    logic [15:0] div_q, baud_cnt_q;
    logic        tick;
    assign tick = (baud_cnt_q == 16'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q      <= 16'(DefaultDiv);
            baud_cnt_q <= 16'd0;
        end else if (div_wr) begin
            div_q      <= data_i;
            baud_cnt_q <= 16'd0;
        end else begin
            baud_cnt_q <= tick ? div_q : baud_cnt_q - 16'd1;
        end
    end

    // FIFOs: extra pointer bit distinguishes full from empty
    logic [DataWidth-1:0] tx_mem [FifoDepth];
    logic [DataWidth-1:0] rx_mem [FifoDepth];
    logic [PtrW:0]        tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic                 tx_full, tx_empty, tx_push, tx_pop;
    logic                 rx_full, rx_empty, rx_push, rx_pop;
    logic [DataWidth-1:0] tx_head, rx_head, rx_sh_q, rx_sh_d;

    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[PtrW] != tx_rp_q[PtrW]) &&
                      (tx_wp_q[PtrW-1:0] == tx_rp_q[PtrW-1:0]);
    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[PtrW] != rx_rp_q[PtrW]) &&
                      (rx_wp_q[PtrW-1:0] == rx_rp_q[PtrW-1:0]);
    assign tx_head  = tx_mem[tx_rp_q[PtrW-1:0]];
    assign rx_head  = rx_mem[rx_rp_q[PtrW-1:0]];
    assign tx_push  = tx_wr && !tx_full;
    assign rx_pop   = rx_rd && !rx_empty;

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp_q[PtrW-1:0]] <= data_i[DataWidth-1:0];
        if (rx_push) rx_mem[rx_wp_q[PtrW-1:0]] <= rx_sh_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
        end
    end

    // Transmitter
    state_e               tx_state_q, tx_state_d;
    logic [3:0]           tx_tick_q, tx_tick_d, tx_idx_q, tx_idx_d;
    logic [DataWidth-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_bit_done;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif
    assign tx_bit_done = tick && (tx_tick_q == 4'd15);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tick ? tx_tick_q + 4'd1 : tx_tick_q;
        tx_idx_d   = tx_idx_q;
        tx_sh_d    = tx_sh_q;
        tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            StIdle: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = StStart;
                    tx_tick_d  = 4'd0;
                    tx_sh_d    = tx_head;
`ifdef UART_PARITY_EN
                    tx_par_d   = ^tx_head;
`endif
                end
            end
            StStart: begin
                if (tx_bit_done) begin
                    tx_state_d = StData;
                    tx_idx_d   = 4'd0;
                end
            end
            StData: begin
                if (tx_bit_done) begin
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_idx_d = tx_idx_q + 4'd1;
`ifdef UART_PARITY_EN
                    if (tx_idx_q == LastIdx) tx_state_d = StParity;
`else
                    if (tx_idx_q == LastIdx) tx_state_d = StStop;
`endif
                end
            end
`ifdef UART_PARITY_EN
            StParity: if (tx_bit_done) tx_state_d = StStop;
`endif
            StStop: begin
                if (tx_bit_done) begin
                    // Back-to-back frames: straight into the next start bit
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_d = StStart;
                        tx_sh_d    = tx_head;
`ifdef UART_PARITY_EN
                        tx_par_d   = ^tx_head;
`endif
                    end else begin
                        tx_state_d = StIdle;
                    end
                end
            end
            default: tx_state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_o = 1'b1;
        case (tx_state_q)
            StStart:  tx_o = 1'b0;
            StData:   tx_o = tx_sh_q[0];
`ifdef UART_PARITY_EN
            StParity: tx_o = tx_par_q;
`endif
            default:  tx_o = 1'b1;
        endcase
    end

    // Receiver
    state_e     rx_state_q, rx_state_d;
    logic [3:0] rx_tick_q, rx_tick_d, rx_idx_q, rx_idx_d;
    logic       rx_meta_q, rx_sync_q, rx_prev_q, rx_mid, rx_bit_end;
    logic       ovr_set, ferr_set, perr_set;
`ifdef UART_PARITY_EN
    logic       rx_par_q, rx_par_d;
`endif
    assign rx_mid     = tick && (rx_tick_q == 4'd7);
    assign rx_bit_end = tick && (rx_tick_q == 4'd15);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = tick ? rx_tick_q + 4'd1 : rx_tick_q;
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        ferr_set   = 1'b0;
        perr_set   = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_d   = rx_par_q;
`endif
        case (rx_state_q)
            StIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = StStart;
                    rx_tick_d  = 4'd0;
                end
            end
            StStart: begin
                if (rx_mid) begin
                    rx_state_d = rx_sync_q ? StIdle : StData;
                    rx_tick_d  = 4'd0;
                    rx_idx_d   = 4'd0;
                end
            end
            StData: begin
                if (rx_bit_end) begin
                    rx_sh_d  = {rx_sync_q, rx_sh_q[DataWidth-1:1]};
                    rx_idx_d = rx_idx_q + 4'd1;
`ifdef UART_PARITY_EN
                    if (rx_idx_q == LastIdx) rx_state_d = StParity;
`else
                    if (rx_idx_q == LastIdx) rx_state_d = StStop;
`endif
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                if (rx_bit_end) begin
                    rx_par_d   = rx_sync_q;
                    rx_state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (rx_bit_end) begin
                    rx_state_d = StIdle;
                    if (!rx_sync_q) ferr_set = 1'b1;
`ifdef UART_PARITY_EN
                    else if ((^rx_sh_q) != rx_par_q) perr_set = 1'b1;
`endif
                    else if (rx_full) ovr_set = 1'b1;
                    else rx_push = 1'b1;
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    // Status, interrupt and read-data registers
    logic        ovr_q, ferr_q, perr_q, irq_q;
    logic [15:0] status, rd_data;
    assign status = {8'd0, perr_q, ferr_q, ovr_q, (tx_state_q != StIdle),
                     rx_full, rx_empty, tx_empty, tx_full};
    assign irq_o  = irq_q;

    always_comb begin
        rd_data = 16'd0;
        case (addr_i)
            2'd1:    rd_data = rx_empty ? 16'd0 : 16'(rx_head);
            2'd2:    rd_data = status;
            2'd3:    rd_data = div_q;
            default: rd_data = 16'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_q <= StIdle;
            tx_tick_q  <= 4'd0;
            tx_idx_q   <= 4'd0;
            tx_sh_q    <= '0;
            rx_state_q <= StIdle;
            rx_tick_q  <= 4'd0;
            rx_idx_q   <= 4'd0;
            rx_sh_q    <= '0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            irq_q      <= 1'b0;
            data_o     <= 16'd0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_idx_q   <= tx_idx_d;
            tx_sh_q    <= tx_sh_d;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_idx_q   <= rx_idx_d;
            rx_sh_q    <= rx_sh_d;
            rx_meta_q  <= rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            // Set beats write-one-to-clear in the same cycle
            ovr_q      <= (ovr_q && !(stat_wr && data_i[5])) || ovr_set;
            ferr_q     <= (ferr_q && !(stat_wr && data_i[6])) || ferr_set;
            perr_q     <= (perr_q && !(stat_wr && data_i[7])) || perr_set;
            irq_q      <= !rx_empty || ovr_q || ferr_q || perr_q;
            if (rd_en_i) data_o <= rd_data;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_par_q <= 1'b0;
            rx_par_q <= 1'b0;
        end else begin
            tx_par_q <= tx_par_d;
            rx_par_q <= rx_par_d;
        end
    end
`endif
endmodule

// File: tb/tb_uart_periph.sv
// Scoreboard bench for uart_periph: register reads and serial TX frames are checked against
// a queue-based model of the FIFOs, flags and frame format.
module tb_uart_periph;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FrameBits = DW + 2 + PB;

    logic        clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] wdata = 16'd0, rdata;
    logic        rx, tx, irq;
    logic        loop = 1'b0, rx_drv = 1'b1;

    assign rx = loop ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_periph dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .wr_en_i (wr_en),
        .rd_en_i (rd_en),
        .addr_i  (addr),
        .data_i  (wdata),
        .data_o  (rdata),
        .rx_i    (rx),
        .tx_o    (tx),
        .irq_o   (irq)
    );

    int n_tests = 0, n_fail = 0;
    int bit_clks = 16 * 54;

    // Reference model state
    logic [15:0]   rd_exp_q[$];
    string         rd_name_q[$];
    logic [DW-1:0] tx_exp_q[$];
    logic [DW-1:0] rx_model[$];
    logic          m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;
    logic          tx_engine_busy = 1'b0;
    int            tx_fifo_n = 0;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_char();
        logic [31:0] r;
        r = $urandom;
        return r[DW-1:0];
    endfunction

    function automatic logic [15:0] exp_status();
        logic [15:0] s;
        s    = 16'd0;
        s[0] = (tx_fifo_n == DEPTH);
        s[1] = (tx_fifo_n == 0);
        s[2] = (rx_model.size() == 0);
        s[3] = (rx_model.size() == DEPTH);
        s[4] = tx_engine_busy;
        s[5] = m_ovr;
        s[6] = m_ferr;
        s[7] = m_perr;
        return s;
    endfunction

    function automatic logic exp_irq();
        return (rx_model.size() != 0) || m_ovr || m_ferr || m_perr;
    endfunction

    function automatic void rx_deliver(input logic [DW-1:0] c);
        if (rx_model.size() == DEPTH) m_ovr = 1'b1;
        else rx_model.push_back(c);
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [15:0] e, input string n);
        rd_exp_q.push_back(e);
        rd_name_q.push_back(n);
        addr  = a;
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic read_status(input string n);
        bus_read(2'd2, exp_status(), n);
    endtask

    task automatic read_rx(input string n);
        logic [15:0] e;
        e = (rx_model.size() != 0) ? 16'(rx_model.pop_front()) : 16'd0;
        bus_read(2'd1, e, n);
    endtask

    task automatic write_status(input logic [15:0] v);
        if (v[5]) m_ovr = 1'b0;
        if (v[6]) m_ferr = 1'b0;
        if (v[7]) m_perr = 1'b0;
        bus_write(2'd2, v);
    endtask

    // Idle transmitter takes the char at once; otherwise it queues if there is room
    task automatic tx_char(input logic [DW-1:0] c);
        logic accepted;
        accepted = 1'b1;
        if (!tx_engine_busy) tx_engine_busy = 1'b1;
        else if (tx_fifo_n < DEPTH) tx_fifo_n++;
        else accepted = 1'b0;
        if (accepted) begin
            tx_exp_q.push_back(c);
            if (loop) rx_deliver(c);
        end
        bus_write(2'd0, 16'(c));
    endtask

    task automatic drain_tx();
        int budget;
        budget = (tx_exp_q.size() + 1) * FrameBits * bit_clks + 100;
        while (tx_exp_q.size() != 0 && budget > 0) begin
            cyc(1);
            budget--;
        end
        check("tx_drain_remaining", 16'(tx_exp_q.size()), 16'd0);
        cyc(2 * bit_clks);
        tx_engine_busy = 1'b0;
        tx_fifo_n      = 0;
    endtask

    task automatic send_frame(input logic [DW-1:0] c, input logic stop, input logic par_flip);
        rx_drv = 1'b0;
        cyc(bit_clks);
        for (int i = 0; i < DW; i++) begin
            rx_drv = c[i];
            cyc(bit_clks);
        end
        if (PB == 1) begin
            rx_drv = (^c) ^ par_flip;
            cyc(bit_clks);
        end
        rx_drv = stop;
        cyc(bit_clks);
        rx_drv = 1'b1;
        cyc(2 * bit_clks);
        if (!stop) m_ferr = 1'b1;
        else if (par_flip && PB == 1) m_perr = 1'b1;
        else rx_deliver(c);
    endtask

    // Read-data monitor
    logic rd_seen = 1'b0;
    always @(posedge clk) rd_seen <= rd_en;

    always @(negedge clk) begin
        if (rd_seen) begin
            n_tests++;
            if (rd_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got 0x%0h expected no read", rdata);
            end else begin
                logic [15:0] e;
                string       nm;
                e  = rd_exp_q.pop_front();
                nm = rd_name_q.pop_front();
                if (rdata !== e) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%04h expected 0x%04h", nm, rdata, e);
                end
            end
        end
    end

    // Serial TX monitor: samples each bit at its centre
    initial begin : tx_mon
        logic [DW+PB:0] got, want;
        logic [DW-1:0]  c;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (bit_clks / 2) @(negedge clk);
                n_tests++;
                if (tx !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tx_start_bit: got %b expected 0", tx);
                end
                for (int i = 0; i <= DW + PB; i++) begin
                    repeat (bit_clks) @(negedge clk);
                    got[i] = tx;
                end
                n_tests++;
                if (tx_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_frame_unexpected: got 0x%0h expected no frame", got);
                end else begin
                    c          = tx_exp_q.pop_front();
                    want       = '0;
                    want[DW-1:0] = c;
                    if (PB == 1) want[DW] = ^c;
                    want[DW+PB] = 1'b1;
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL tx_frame: got 0x%0h expected 0x%0h", got, want);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] c;
        cyc(2);
        rst = 1'b0;

        // Reset state
        check("reset_tx", {15'd0, tx}, 16'd1);
        check("reset_irq", {15'd0, irq}, 16'd0);
        check("reset_data_o", rdata, 16'd0);
        read_status("reset_status");
        bus_read(2'd3, 16'd53, "reset_bauddiv");
        read_rx("reset_rx_empty_read");

        bus_write(2'd3, 16'd0);
        bit_clks = 16;
        bus_read(2'd3, 16'd0, "bauddiv_zero");

        // Single frame, start latency and tx_empty right after the pop
        tx_char(8'h5A);
        cyc(1);
        check("tx_start_latency", {15'd0, tx}, 16'd0);
        read_status("status_after_pop");
        drain_tx();
        read_status("status_tx_idle");

        // Loopback: fixed then random characters
        loop = 1'b1;
        tx_char(8'h00);
        tx_char(8'hFF);
        tx_char(8'hA5);
        drain_tx();
        read_status("loop_status_pending");
        for (int i = 0; i < 3; i++) read_rx("loop_rxdata");
        read_status("loop_status_empty");
        read_rx("loop_rx_empty_read");
        for (int i = 0; i < 4; i++) tx_char(rnd_char());
        drain_tx();
        for (int i = 0; i < 4; i++) read_rx("loop_rand_rxdata");

        // Slower baud rate
        bus_write(2'd3, 16'd2);
        bit_clks = 48;
        tx_char(rnd_char());
        drain_tx();
        read_rx("div2_rxdata");
        bus_write(2'd3, 16'd0);
        bit_clks = 16;
        loop = 1'b0;
        cyc(2);
        check("irq_idle", {15'd0, irq}, {15'd0, exp_irq()});

        // Framing error and write-one-to-clear
        send_frame(rnd_char(), 1'b0, 1'b0);
        cyc(2);
        check("irq_ferr", {15'd0, irq}, {15'd0, exp_irq()});
        read_status("ferr_status");
        write_status(16'h0020);
        read_status("ferr_after_ovr_clear");
        write_status(16'h0040);
        read_status("ferr_cleared");
        cyc(2);
        check("irq_after_clear", {15'd0, irq}, {15'd0, exp_irq()});

        // Short low glitch must not start a character
        rx_drv = 1'b0;
        cyc(3);
        rx_drv = 1'b1;
        cyc(40);
        read_status("glitch_status");
        read_rx("glitch_rx_empty_read");

        // TX FIFO full: one char in flight, then nine writes
        tx_char(rnd_char());
        cyc(4);
        for (int i = 0; i < 9; i++) tx_char(rnd_char());
        read_status("tx_full_status");
        drain_tx();
        read_status("tx_full_drained");

        // RX FIFO overflow
        for (int i = 0; i < 9; i++) begin
            c = rnd_char();
            send_frame(c, 1'b1, 1'b0);
        end
        read_status("rx_full_status");
        check("irq_rx_full", {15'd0, irq}, {15'd0, exp_irq()});
        for (int i = 0; i < DEPTH; i++) read_rx("rx_full_rxdata");
        read_status("rx_ovr_sticky");
        write_status(16'h0020);
        read_status("rx_ovr_cleared");

`ifdef UART_PARITY_EN
        tx_char(8'h07);
        drain_tx();
        send_frame(rnd_char(), 1'b1, 1'b1);
        read_status("perr_status");
        read_rx("perr_rx_empty_read");
        write_status(16'h0080);
        read_status("perr_cleared");
`endif

        cyc(4);
        check("tx_exp_left", 16'(tx_exp_q.size()), 16'd0);
        check("rd_exp_left", 16'(rd_exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
